// File: rtl/am2942_dma_seq_if.sv
// Bus bundle between the DMA sequencer, its host/peripheral side and the am2942
// address/word-count generator. The master modport is the sequencer.
interface am2942_dma_seq_if;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic       dec;
    logic [7:0] addr_in;
    logic [7:0] cnt_in;
    logic       dreq;
    logic       dack;
    logic       irq;
    logic       irq_ack;
    logic       busy;
    logic [7:0] nxfer;
    logic [3:0] i;
    logic       ien_;
    logic       oed_;
    logic [7:0] d_out;
    logic       d_oe;
    logic       aci_;
    logic       wci_;
    logic       done_in;

    modport master (
        input  start, abort, mode, dec, addr_in, cnt_in, dreq, irq_ack, done_in,
        output dack, irq, busy, nxfer, i, ien_, oed_, d_out, d_oe, aci_, wci_
    );

    modport slave (
        output start, abort, mode, dec, addr_in, cnt_in, dreq, irq_ack, done_in,
        input  dack, irq, busy, nxfer, i, ien_, oed_, d_out, d_oe, aci_, wci_
    );
endinterface

// File: rtl/am2942_dma_seq.sv
// DMA channel sequencer: programs an am2942, then steps it once per dreq/dack
// transfer until the am2942 reports done, then reloads it and raises irq.
module am2942_dma_seq (
    input  logic                   cp,
    input  logic                   rst,
    am2942_dma_seq_if.master       bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRCR,
        S_LDAD,
        S_LDWC,
        S_REQ,
        S_XFER,
        S_FIN
    } state_t;

    localparam logic [3:0] I_WRCR = 4'b0000;
    localparam logic [3:0] I_REIN = 4'b0100;
    localparam logic [3:0] I_LDAD = 4'b0101;
    localparam logic [3:0] I_LDWC = 4'b0110;

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] mode_q, mode_d;
    logic       dec_q, dec_d;
    logic [7:0] nxfer_q, nxfer_d;
    logic       irq_q, irq_d;

    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            dec_q   <= 1'b0;
            nxfer_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dec_q   <= dec_d;
            nxfer_q <= nxfer_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dec_d   = dec_q;
        nxfer_d = nxfer_q;
        irq_d   = irq_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_WRCR;
                    addr_d  = bus.addr_in;
                    cnt_d   = bus.cnt_in;
                    mode_d  = bus.mode;
                    dec_d   = bus.dec;
                    nxfer_d = '0;
                end
            end
            S_WRCR: state_d = S_LDAD;
            S_LDAD: state_d = S_LDWC;
            S_LDWC: state_d = S_REQ;
            S_REQ: begin
                if (bus.dreq) state_d = S_XFER;
            end
            S_XFER: begin
                nxfer_d = nxfer_q + 8'd1;
                state_d = bus.done_in ? S_FIN : S_REQ;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides any progress, including the XFER count step.
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
            nxfer_d = nxfer_q;
        end

        // Setting on FIN beats a coincident irq_ack.
        if (state_q == S_FIN && !bus.abort) begin
            irq_d = 1'b1;
        end else if ((state_q == S_IDLE && bus.start) || bus.irq_ack) begin
            irq_d = 1'b0;
        end
    end

    // All am2942-side outputs decode from the state register and latched data.
    always_comb begin
        bus.i     = I_WRCR;
        bus.ien_  = 1'b1;
        bus.oed_  = 1'b1;
        bus.d_oe  = 1'b0;
        bus.d_out = '0;
        bus.aci_  = 1'b1;
        bus.wci_  = 1'b1;
        bus.dack  = 1'b0;

        case (state_q)
            S_WRCR: begin
                bus.i     = I_WRCR;
                bus.ien_  = 1'b0;
                bus.d_oe  = 1'b1;
                bus.d_out = {5'b00000, dec_q, mode_q};
            end
            S_LDAD: begin
                bus.i     = I_LDAD;
                bus.ien_  = 1'b0;
                bus.d_oe  = 1'b1;
                bus.d_out = addr_q;
            end
            S_LDWC: begin
                bus.i     = I_LDWC;
                bus.ien_  = 1'b0;
                bus.d_oe  = 1'b1;
                bus.d_out = cnt_q;
            end
            S_XFER: begin
                bus.dack = 1'b1;
                bus.oed_ = 1'b0;
                bus.aci_ = 1'b0;
                bus.wci_ = 1'b0;
            end
            S_FIN: begin
                bus.i    = I_REIN;
                bus.ien_ = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.busy  = (state_q != S_IDLE);
    assign bus.irq   = irq_q;
    assign bus.nxfer = nxfer_q;

endmodule

// File: tb/tb_am2942_dma_seq.sv
// Scoreboard bench for am2942_dma_seq with a behavioural am2942 counter model.
module tb_am2942_dma_seq;

    logic cp;
    logic rst;

    am2942_dma_seq_if bus ();

    am2942_dma_seq dut (
        .cp  (cp),
        .rst (rst),
        .bus (bus)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    int n_checks = 0;
    int n_fail   = 0;
    int dack_count = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] nxfer;
    } xfer_t;

    xfer_t      xq[$];
    logic [7:0] irq_q[$];

    // am2942 model: control register, address and word counters.
    logic [7:0] m_creg, m_ar, m_ac, m_wr, m_wc;
    logic [7:0] bus_d;

    assign bus_d       = bus.d_oe ? bus.d_out : (!bus.oed_ ? m_ac : 8'h00);
    assign bus.done_in = (m_wc == 8'd1);

    always @(posedge cp) begin
        if (!bus.ien_) begin
            case (bus.i)
                4'b0000: m_creg <= bus_d;
                4'b0101: begin m_ar <= bus_d; m_ac <= bus_d; end
                4'b0110: begin m_wr <= bus_d; m_wc <= bus_d; end
                4'b0100: begin m_ac <= m_ar;  m_wc <= m_wr;  end
                default: ;
            endcase
        end else begin
            if (!bus.aci_) m_ac <= m_creg[2] ? m_ac - 8'd1 : m_ac + 8'd1;
            if (!bus.wci_) m_wc <= m_wc - 8'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every dack and every irq rise is matched against the scoreboard.
    logic irq_prev = 1'b0;
    always @(negedge cp) begin
        if (bus.dack) begin
            dack_count++;
            if (xq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_dack: got dack=1 with addr 0x%0h expected no transfer", bus_d);
            end else begin
                xfer_t e;
                e = xq.pop_front();
                chk("dack_addr", {24'd0, bus_d}, {24'd0, e.addr});
                chk("dack_nxfer", {24'd0, bus.nxfer}, {24'd0, e.nxfer});
                chk("dack_bus_ctl", {28'd0, bus.oed_, bus.d_oe, bus.aci_, bus.wci_}, 32'h0);
            end
        end
        if (bus.irq && !irq_prev) begin
            if (irq_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_irq: got irq=1 nxfer 0x%0h expected no completion", bus.nxfer);
            end else begin
                logic [7:0] en;
                en = irq_q.pop_front();
                chk("irq_nxfer", {24'd0, bus.nxfer}, {24'd0, en});
            end
        end
        irq_prev <= bus.irq;
    end

    task automatic tick();
        @(negedge cp);
    endtask

    task automatic kick(input logic [7:0] a, input logic [7:0] c,
                        input logic [1:0] m, input logic d);
        bus.addr_in = a;
        bus.cnt_in  = c;
        bus.mode    = m;
        bus.dec     = d;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    // Checks WRCR/LDAD/LDWC/REQ, starting in the WRCR cycle; ends in REQ.
    task automatic chk_program(input logic [7:0] cr, input logic [7:0] a, input logic [7:0] c);
        chk("wrcr", {bus.i, bus.ien_, bus.d_oe, bus.d_out}, {4'h0, 1'b0, 1'b1, cr});
        tick();
        chk("ldad", {bus.i, bus.ien_, bus.d_oe, bus.d_out}, {4'h5, 1'b0, 1'b1, a});
        tick();
        chk("ldwc", {bus.i, bus.ien_, bus.d_oe, bus.d_out}, {4'h6, 1'b0, 1'b1, c});
        tick();
        chk("req", {bus.i, bus.ien_, bus.d_oe, bus.busy, bus.dack}, {4'h0, 1'b1, 1'b0, 1'b1, 1'b0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.mode    = 2'b00;
        bus.dec     = 1'b0;
        bus.addr_in = 8'h00;
        bus.cnt_in  = 8'h00;
        bus.dreq    = 1'b0;
        bus.irq_ack = 1'b0;
        tick();
        chk("reset_outs",
            {bus.i, bus.ien_, bus.oed_, bus.d_oe, bus.d_out, bus.aci_, bus.wci_, bus.dack, bus.busy, bus.irq, bus.nxfer},
            {4'h0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        rst = 1'b0;
        tick();

        // Full block, dreq held high: dacks on cycles 5,7,9.
        xq.push_back('{8'h40, 8'h00});
        xq.push_back('{8'h41, 8'h01});
        xq.push_back('{8'h42, 8'h02});
        irq_q.push_back(8'h03);
        base = dack_count;
        bus.dreq = 1'b1;
        kick(8'h40, 8'h03, 2'b00, 1'b0);
        chk_program(8'h00, 8'h40, 8'h03);
        repeat (6) tick();
        chk("fin", {bus.i, bus.ien_, bus.busy, bus.irq}, {4'h4, 1'b0, 1'b1, 1'b0});
        tick();
        chk("block_end", {bus.irq, bus.busy, bus.nxfer, bus.i, bus.ien_}, {1'b1, 1'b0, 8'h03, 4'h0, 1'b1});
        chk("block_dacks", dack_count - base, 3);
        bus.dreq = 1'b0;
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        chk("irq_ack_clear", {31'd0, bus.irq}, 32'd0);

        // dreq gaps of 4 cycles; counters must hold while in REQ.
        xq.push_back('{8'h40, 8'h00});
        xq.push_back('{8'h41, 8'h01});
        xq.push_back('{8'h42, 8'h02});
        irq_q.push_back(8'h03);
        base = dack_count;
        kick(8'h40, 8'h03, 2'b00, 1'b0);
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            repeat (4) begin
                tick();
                chk("gap_ctl", {bus.aci_, bus.wci_, bus.dack, bus.busy}, 4'b1101);
                chk("gap_ctr", {m_ac, m_wc}, {8'h40 + 8'(k), 8'h03 - 8'(k)});
            end
            bus.dreq = 1'b1;
            tick();
            bus.dreq = 1'b0;
        end
        tick();
        chk("gap_fin", {bus.i, bus.ien_}, {4'h4, 1'b0});
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        chk("ack_vs_fin", {bus.irq, bus.busy, bus.nxfer}, {1'b1, 1'b0, 8'h03});
        chk("gap_dacks", dack_count - base, 3);

        // Abort in the second REQ.
        xq.push_back('{8'h40, 8'h00});
        base = dack_count;
        bus.dreq = 1'b1;
        kick(8'h40, 8'h03, 2'b00, 1'b0);
        repeat (5) tick();
        chk("abort_in_req", {bus.busy, bus.dack, bus.ien_}, 3'b101);
        bus.abort = 1'b1;
        bus.dreq  = 1'b0;
        tick();
        bus.abort = 1'b0;
        chk("abort_idle", {bus.busy, bus.irq, bus.nxfer}, {1'b0, 1'b0, 8'h01});
        bus.dreq = 1'b1;
        repeat (4) tick();
        bus.dreq = 1'b0;
        chk("abort_no_dack", dack_count - base, 1);
        chk("abort_stay_idle", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset in the middle of an XFER cycle.
        xq.push_back('{8'h40, 8'h00});
        bus.dreq = 1'b1;
        kick(8'h40, 8'h03, 2'b00, 1'b0);
        repeat (4) tick();
        #2 rst = 1'b1;
        #1 chk("rst_mid_xfer", {bus.dack, bus.busy, bus.oed_, bus.aci_, bus.wci_, bus.nxfer}, {5'b00111, 8'h00});
        tick();
        rst = 1'b0;
        bus.dreq = 1'b0;
        tick();

        // Reprogram with dec=1; start during REQ is ignored.
        xq.push_back('{8'h10, 8'h00});
        xq.push_back('{8'h0F, 8'h01});
        irq_q.push_back(8'h02);
        kick(8'h10, 8'h02, 2'b00, 1'b1);
        chk_program(8'h04, 8'h10, 8'h02);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_ignored", {bus.i, bus.ien_, bus.d_oe, bus.busy}, {4'h0, 1'b1, 1'b0, 1'b1});
        tick();
        chk("still_req", {bus.ien_, bus.busy, bus.dack}, 3'b110);
        bus.dreq = 1'b1;
        repeat (5) tick();
        bus.dreq = 1'b0;
        chk("dec_block_end", {bus.irq, bus.busy, bus.nxfer}, {1'b1, 1'b0, 8'h02});
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        chk("irq_ack_clear2", {31'd0, bus.irq}, 32'd0);

        tick();
        chk("xq_drained", xq.size(), 0);
        chk("irq_q_drained", irq_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
